decryption_scheduler: RTL and testbench

Shares one `decryption_top` AES-128 decryption core between two requester ports. Grants requests round-robin and latches the selected ciphertext/key pair. Issues a one-cycle start pulse to the core and holds the core inputs stable for the whole operation. Returns the plaintext, or a timeout error, on the owning requester's response port. Sits directly above the core and drives its `start`, `ciphertext` and `key` inputs.

---
 rtl/decryption_scheduler.sv | 144 ++++++++++++++
 tb/tb_decryption_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decryption_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : decryption_scheduler
// Description : Round-robin arbiter that shares one AES-128 decryption core
//               between two requesters. Latches the granted operands, pulses
//               the core start, waits for done (with timeout) and returns the
//               plaintext or an error to the owning requester.
// Revision    : 1.0 - initial release
// ============================================================================
module decryption_scheduler #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [127:0] req_ciphertext0,
    input  logic [127:0] req_ciphertext1,
    input  logic [127:0] req_key0,
    input  logic [127:0] req_key1,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [127:0] rsp_plaintext,
    output logic         rsp_error,
    output logic         core_start,
    output logic [127:0] core_ciphertext,
    output logic [127:0] core_key,
    input  logic [127:0] core_plaintext,
    input  logic         core_done,
    output logic         busy
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_LAUNCH = 2'd1;
    localparam logic [1:0] c_WAIT   = 2'd2;
    localparam logic [1:0] c_RESP   = 2'd3;

    localparam int                c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [1:0]         r_state;
    logic               r_last_grant;
    logic               r_owner;
    logic [c_CNT_W-1:0] r_cnt;
    logic [127:0]       r_ciphertext;
    logic [127:0]       r_key;
    logic [127:0]       r_plaintext;
    logic               r_error;
    logic               r_start;
    logic [1:0]         r_rsp_valid;
    logic               r_busy;

    logic               w_grant;
    logic               w_accept;

    // Arbitration: a lone requester wins outright; a tie goes to whoever
    // was not served last. Ready is offered only while idle.
    always_comb begin
        w_grant   = 1'b0;
        w_accept  = 1'b0;
        req_ready = 2'b00;
        if (req_valid == 2'b11) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = ~req_valid[0];
        end
        w_accept = (r_state == c_IDLE) && (req_valid != 2'b00);
        if (w_accept) begin
            req_ready = w_grant ? 2'b10 : 2'b01;
        end
    end

    // Operation sequencer: accept, launch, wait for done or timeout, respond.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_cnt        <= '0;
            r_ciphertext <= '0;
            r_key        <= '0;
            r_plaintext  <= '0;
            r_error      <= 1'b0;
            r_start      <= 1'b0;
            r_rsp_valid  <= 2'b00;
            r_busy       <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_ciphertext <= w_grant ? req_ciphertext1 : req_ciphertext0;
                        r_key        <= w_grant ? req_key1 : req_key0;
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        r_start      <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= c_LAUNCH;
                    end
                end
                c_LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                    // done takes priority over a timeout landing in the same cycle
                    if (core_done) begin
                        r_plaintext <= core_plaintext;
                        r_error     <= 1'b0;
                        r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
                        r_state     <= c_RESP;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_plaintext <= '0;
                        r_error     <= 1'b1;
                        r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
                        r_state     <= c_RESP;
                    end
                end
                c_RESP: begin
                    if (rsp_ready[r_owner]) begin
                        r_rsp_valid <= 2'b00;
                        r_busy      <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid       = r_rsp_valid;
    assign rsp_plaintext   = r_plaintext;
    assign rsp_error       = r_error;
    assign core_start      = r_start;
    assign core_ciphertext = r_ciphertext;
    assign core_key        = r_key;
    assign busy            = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_decryption_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_decryption_scheduler
// Description : Directed self-checking bench for decryption_scheduler with a
//               behavioural core stub of programmable latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decryption_scheduler;

    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CA = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KA = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CB = 128'hdeadbeef0badf00dcafebabe12345678;
    localparam logic [127:0] KB = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] PA = CA ^ KA;
    localparam logic [127:0] PB = CB ^ KB;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [127:0] req_ciphertext0, req_ciphertext1, req_key0, req_key1;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [127:0] rsp_plaintext;
    logic         rsp_error;
    logic         core_start;
    logic [127:0] core_ciphertext, core_key, core_plaintext;
    logic         core_done;
    logic         busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // core stub controls
    logic stub_en;
    int   stub_lat;
    int   stub_cnt;
    logic stray_done;

    always #5 clk = ~clk;

    decryption_scheduler #(.TIMEOUT_CYCLES(8)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_ciphertext0 (req_ciphertext0),
        .req_ciphertext1 (req_ciphertext1),
        .req_key0        (req_key0),
        .req_key1        (req_key1),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_plaintext   (rsp_plaintext),
        .rsp_error       (rsp_error),
        .core_start      (core_start),
        .core_ciphertext (core_ciphertext),
        .core_key        (core_key),
        .core_plaintext  (core_plaintext),
        .core_done       (core_done),
        .busy            (busy)
    );

    // Core stub: done pulses stub_lat cycles after the start pulse.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)                  stub_cnt <= 0;
        else if (core_start && stub_en) stub_cnt <= stub_lat;
        else if (stub_cnt != 0)         stub_cnt <= stub_cnt - 1;
    end
    assign core_done      = (stub_cnt == 1) | stray_done;
    assign core_plaintext = (core_ciphertext == C1 && core_key == K1) ? P1
                                                                      : (core_ciphertext ^ core_key);

    // Issue one request and return grant, cycles from acceptance to rsp_valid
    // (-1 if none within the budget) and the number of start pulses seen.
    task automatic run_op(input logic [1:0] v, input logic keep,
                          output logic [1:0] grant, output int lat, output int starts);
        grant  = 2'b00;
        lat    = -1;
        starts = 0;
        @(negedge clk);
        rsp_ready = 2'b00;
        req_valid = v;
        #1;
        for (int i = 0; i < 20 && req_ready == 2'b00; i++) begin
            @(negedge clk);
            #1;
        end
        grant = req_ready;
        if (grant == 2'b00) return;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!keep && k == 1) begin
                req_valid       = 2'b00;
                req_ciphertext0 = '1;
                req_ciphertext1 = '1;
                req_key0        = '1;
                req_key1        = '1;
            end
            if (core_start) starts++;
            if (rsp_valid != 2'b00) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 2'b00 || rsp_plaintext !== '0 || rsp_error !== 1'b0 ||
            core_start !== 1'b0 || core_ciphertext !== '0 || core_key !== '0 ||
            busy !== 1'b0 || req_ready !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_values: rsp_valid=%b err=%b start=%b busy=%b ready=%b required all zero",
                     rsp_valid, rsp_error, core_start, busy, req_ready);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_arbitration;
        logic [1:0]   g;
        logic [1:0]   exp_g;
        logic [127:0] exp_p;
        int           lat, st;
        req_ciphertext0 = CA; req_key0 = KA;
        req_ciphertext1 = CB; req_key1 = KB;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_p = (i % 2 == 0) ? PA : PB;
            run_op(2'b11, 1'b1, g, lat, st);
            tests_run++;
            if (g !== exp_g) begin
                tests_failed++;
                $display("FAIL arb_grant[%0d]: got %b required %b", i, g, exp_g);
            end
            tests_run++;
            if (rsp_valid !== exp_g || rsp_plaintext !== exp_p || lat != 5 || st != 1) begin
                tests_failed++;
                $display("FAIL arb_rsp[%0d]: valid=%b pt=%h lat=%0d starts=%0d required valid=%b pt=%h lat=5 starts=1",
                         i, rsp_valid, rsp_plaintext, lat, st, exp_g, exp_p);
            end
            rsp_ready = 2'b11;
        end
        @(negedge clk);
        rsp_ready = 2'b00;
        req_valid = 2'b00;
    endtask

    task automatic test_single;
        logic [1:0] g;
        int         lat, st;
        req_ciphertext0 = C1; req_key0 = K1;
        run_op(2'b01, 1'b0, g, lat, st);
        tests_run++;
        if (g !== 2'b01 || lat != 5 || st != 1) begin
            tests_failed++;
            $display("FAIL single_launch: grant=%b lat=%0d starts=%0d required 01/5/1", g, lat, st);
        end
        tests_run++;
        if (rsp_valid !== 2'b01 || rsp_plaintext !== P1 || rsp_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_rsp: valid=%b pt=%h err=%b required 01 %h 0",
                     rsp_valid, rsp_plaintext, rsp_error, P1);
        end
        tests_run++;
        if (core_ciphertext !== C1 || core_key !== K1) begin
            tests_failed++;
            $display("FAIL single_hold: ct=%h key=%h required %h %h", core_ciphertext, core_key, C1, K1);
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        tests_run++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_release: valid=%b busy=%b required 00 0", rsp_valid, busy);
        end
    endtask

    task automatic test_backpressure;
        logic [1:0] g;
        int         lat, st;
        req_ciphertext1 = CB; req_key1 = KB;
        run_op(2'b10, 1'b0, g, lat, st);
        tests_run++;
        if (g !== 2'b10 || lat != 5 || rsp_valid !== 2'b10 || rsp_plaintext !== PB) begin
            tests_failed++;
            $display("FAIL bp_rsp: grant=%b lat=%0d valid=%b pt=%h required 10/5/10/%h",
                     g, lat, rsp_valid, rsp_plaintext, PB);
        end
        rsp_ready = 2'b01;   // non-owner bit only
        req_valid = 2'b11;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            tests_run++;
            if (rsp_valid !== 2'b10 || rsp_plaintext !== PB || req_ready !== 2'b00 ||
                core_start !== 1'b0 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: valid=%b pt=%h ready=%b start=%b busy=%b required 10 %h 00 0 1",
                         i, rsp_valid, rsp_plaintext, req_ready, core_start, busy, PB);
            end
        end
        rsp_ready = 2'b10;
        req_valid = 2'b00;
        @(negedge clk);
        rsp_ready = 2'b00;
        tests_run++;
        if (rsp_valid !== 2'b00) begin
            tests_failed++;
            $display("FAIL bp_release: valid=%b required 00", rsp_valid);
        end
    endtask

    task automatic test_timeout;
        logic [1:0] g;
        int         lat, st;
        stub_en = 1'b0;
        req_ciphertext0 = CA; req_key0 = KA;
        run_op(2'b01, 1'b0, g, lat, st);
        tests_run++;
        if (lat != 10 || rsp_valid !== 2'b01 || rsp_error !== 1'b1 || rsp_plaintext !== '0) begin
            tests_failed++;
            $display("FAIL timeout_rsp: lat=%0d valid=%b err=%b pt=%h required 10 01 1 0",
                     lat, rsp_valid, rsp_error, rsp_plaintext);
        end
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        tests_run++;
        if (rsp_valid !== 2'b01 || rsp_error !== 1'b1 || rsp_plaintext !== '0) begin
            tests_failed++;
            $display("FAIL stray_done_resp: valid=%b err=%b pt=%h required 01 1 0",
                     rsp_valid, rsp_error, rsp_plaintext);
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready  = 2'b00;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        tests_run++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_plaintext !== '0 || core_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL stray_done_idle: valid=%b busy=%b pt=%h start=%b required 00 0 0 0",
                     rsp_valid, busy, rsp_plaintext, core_start);
        end
        stub_en = 1'b1;
    endtask

    task automatic test_coincidence;
        logic [1:0] g;
        int         lat, st;
        stub_lat = 8;        // done lands in the last timeout cycle
        req_ciphertext1 = CB; req_key1 = KB;
        run_op(2'b10, 1'b0, g, lat, st);
        tests_run++;
        if (lat != 10 || rsp_valid !== 2'b10 || rsp_error !== 1'b0 || rsp_plaintext !== PB) begin
            tests_failed++;
            $display("FAIL coincidence: lat=%0d valid=%b err=%b pt=%h required 10 10 0 %h",
                     lat, rsp_valid, rsp_error, rsp_plaintext, PB);
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        rsp_ready = 2'b00;
        stub_lat  = 3;
    endtask

    task automatic test_reset_mid;
        logic [1:0] g;
        int         lat, st;
        int         stray;
        stub_lat = 6;
        req_ciphertext0 = CA; req_key0 = KA;
        @(negedge clk);
        req_valid = 2'b01;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);       // now in WAIT
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (rsp_valid !== 2'b00 || rsp_plaintext !== '0 || rsp_error !== 1'b0 ||
            core_start !== 1'b0 || core_ciphertext !== '0 || core_key !== '0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_values: valid=%b pt=%h err=%b ct=%h busy=%b required all zero",
                     rsp_valid, rsp_plaintext, rsp_error, core_ciphertext, busy);
        end
        @(negedge clk);
        reset_n  = 1'b1;
        stub_lat = 3;
        stray    = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (rsp_valid !== 2'b00) stray++;
        end
        tests_run++;
        if (stray != 0) begin
            tests_failed++;
            $display("FAIL reset_mid_no_rsp: %0d cycles with rsp_valid required 0", stray);
        end
        req_ciphertext0 = CA; req_key0 = KA;
        req_ciphertext1 = CB; req_key1 = KB;
        run_op(2'b11, 1'b0, g, lat, st);
        tests_run++;
        if (g !== 2'b01 || lat != 5 || rsp_valid !== 2'b01 || rsp_plaintext !== PA || rsp_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_after: grant=%b lat=%0d valid=%b pt=%h required 01 5 01 %h",
                     g, lat, rsp_valid, rsp_plaintext, PA);
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
    endtask

    initial begin
        reset_n         = 1'b0;
        req_valid       = 2'b00;
        rsp_ready       = 2'b00;
        req_ciphertext0 = '0;
        req_ciphertext1 = '0;
        req_key0        = '0;
        req_key1        = '0;
        stub_en         = 1'b1;
        stub_lat        = 3;
        stray_done      = 1'b0;

        test_reset();
        test_arbitration();
        test_single();
        test_backpressure();
        test_timeout();
        test_coincidence();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
`default_nettype wire
